// File: rtl/rv32v_types_pkg.sv
// Shared types for the RV32V memory sequencer: element widths, addressing modes,
// FSM states and byte-lane helpers.
package rv32v_types_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } vsew_t;

    typedef enum logic [1:0] {
        VM_UNIT    = 2'd0,
        VM_STRIDED = 2'd1,
        VM_INDEXED = 2'd2,
        VM_RSVD    = 2'd3
    } vmemmode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } seq_state_t;

    // SEW64 has no lane on a 32-bit bus; it is treated as a full word.
    function automatic logic [3:0] lane_mask(input vsew_t sew);
        case (sew)
            SEW8:    return 4'b0001;
            SEW16:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] elem_bytes(input vsew_t sew);
        case (sew)
            SEW8:    return 3'd1;
            SEW16:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/rv32v_mem_addr_gen.sv
// Combinational address, byte-lane and alignment generation for one vector element.
module rv32v_mem_addr_gen
    import rv32v_types_pkg::*;
#(
    parameter int IW = 5
) (
    input  logic [31:0]   base,
    input  logic [31:0]   stride_acc,
    input  logic [1:0]    mode,
    input  logic [1:0]    deew,
    input  logic [1:0]    ieew,
    input  logic [IW-1:0] elem,
    input  logic [31:0]   idx_data,
    input  logic [31:0]   store_data,
    input  logic [31:0]   load_data,
    output logic [31:0]   addr,
    output logic [3:0]    byte_en,
    output logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          misaligned
);

    logic [31:0] elem_ext_s;
    logic [1:0]  offset_s;
    logic [2:0]  eb_s;
    logic [3:0]  dmask_s;

    assign elem_ext_s = {{(32-IW){1'b0}}, elem};

    // Effective address by mode; strided uses the caller's running accumulator.
    always_comb begin
        addr = base;
        case (vmemmode_t'(mode))
            VM_UNIT:    addr = base + (elem_ext_s << deew);
            VM_STRIDED: addr = base + stride_acc;
            VM_INDEXED: addr = base + (idx_data & expand_mask(lane_mask(vsew_t'(ieew))));
            default:    addr = base + (elem_ext_s << deew);
        endcase
    end

    // Lane placement of the element within the addressed word.
    always_comb begin
        offset_s   = addr[1:0];
        eb_s       = elem_bytes(vsew_t'(deew));
        dmask_s    = lane_mask(vsew_t'(deew));
        misaligned = (({1'b0, offset_s} + eb_s) > 3'd4);
        byte_en    = dmask_s << offset_s;
        wdata      = store_data << {offset_s, 3'b000};
        rdata      = (load_data >> {offset_s, 3'b000}) & expand_mask(dmask_s);
    end

endmodule

// File: rtl/rv32v_mem_sequencer.sv
// Vector load/store element sequencer: walks evl elements, issues one memory
// request at a time, writes load data back, and flags misaligned elements.
module rv32v_mem_sequencer
    import rv32v_types_pkg::*;
#(
    parameter int MAXEL = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic [31:0]               base_addr,
    input  logic [31:0]               stride,
    input  logic [1:0]                mode,
    input  logic [1:0]                deew,
    input  logic [1:0]                ieew,
    input  logic [5:0]                evl,
    input  logic                      is_store,
    input  logic                      mask_en,
    input  logic [31:0]               vmask,
    output logic [$clog2(MAXEL)-1:0]  elem_idx,
    input  logic [31:0]               vs2_rdata,
    input  logic [31:0]               vs3_rdata,
    output logic                      mreq_valid,
    output logic [31:0]               maddr,
    output logic                      mwen,
    output logic [3:0]                mbyte_en,
    output logic [31:0]               mwdata,
    input  logic                      mreq_ready,
    input  logic                      mresp_valid,
    input  logic [31:0]               mresp_rdata,
    output logic                      wb_en,
    output logic [$clog2(MAXEL)-1:0]  wb_elem,
    output logic [31:0]               wb_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [$clog2(MAXEL)-1:0]  err_elem
);

    localparam int IW = $clog2(MAXEL);

    seq_state_t    state_r;
    logic [IW-1:0] i_r;
    logic [31:0]   acc_r;
    logic [31:0]   base_r;
    logic [31:0]   stride_r;
    logic [1:0]    mode_r;
    logic [1:0]    deew_r;
    logic [1:0]    ieew_r;
    logic [5:0]    evl_r;
    logic          is_store_r;
    logic          mask_en_r;
    logic [31:0]   vmask_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;
    logic [IW-1:0] err_elem_r;

    logic [31:0]   addr_s;
    logic [3:0]    byte_en_s;
    logic [31:0]   wdata_s;
    logic [31:0]   rdata_s;
    logic          misaligned_s;
    logic          skip_s;
    logic          last_s;
    logic          req_s;
    logic          wb_s;

    rv32v_mem_addr_gen #(.IW(IW)) u_addr_gen (
        .base       (base_r),
        .stride_acc (acc_r),
        .mode       (mode_r),
        .deew       (deew_r),
        .ieew       (ieew_r),
        .elem       (i_r),
        .idx_data   (vs2_rdata),
        .store_data (vs3_rdata),
        .load_data  (mresp_rdata),
        .addr       (addr_s),
        .byte_en    (byte_en_s),
        .wdata      (wdata_s),
        .rdata      (rdata_s),
        .misaligned (misaligned_s)
    );

    assign skip_s = mask_en_r && !vmask_r[i_r];
    assign last_s = (({{(32-IW){1'b0}}, i_r} + 32'd1) == {26'd0, evl_r});
    assign req_s  = (state_r == ST_ISSUE) && !skip_s && !misaligned_s;
    assign wb_s   = (state_r == ST_WAIT) && mresp_valid && !is_store_r;

    assign elem_idx = i_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign err_elem = err_elem_r;

    // Memory request fields are zero whenever no request is being offered.
    always_comb begin
        mreq_valid = 1'b0;
        maddr      = 32'd0;
        mwen       = 1'b0;
        mbyte_en   = 4'd0;
        mwdata     = 32'd0;
        if (req_s) begin
            mreq_valid = 1'b1;
            maddr      = addr_s;
            mwen       = is_store_r;
            mbyte_en   = byte_en_s;
            mwdata     = wdata_s;
        end else begin
            mreq_valid = 1'b0;
        end
    end

    // Load writeback coincides with the accepted response.
    always_comb begin
        wb_en   = 1'b0;
        wb_elem = '0;
        wb_data = 32'd0;
        if (wb_s) begin
            wb_en   = 1'b1;
            wb_elem = i_r;
            wb_data = rdata_s;
        end else begin
            wb_en   = 1'b0;
        end
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            i_r        <= '0;
            acc_r      <= 32'd0;
            base_r     <= 32'd0;
            stride_r   <= 32'd0;
            mode_r     <= 2'd0;
            deew_r     <= 2'd0;
            ieew_r     <= 2'd0;
            evl_r      <= 6'd0;
            is_store_r <= 1'b0;
            mask_en_r  <= 1'b0;
            vmask_r    <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_elem_r <= '0;
        end else begin
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_elem_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_r     <= base_addr;
                        stride_r   <= stride;
                        mode_r     <= mode;
                        deew_r     <= deew;
                        ieew_r     <= ieew;
                        evl_r      <= evl;
                        is_store_r <= is_store;
                        mask_en_r  <= mask_en;
                        vmask_r    <= vmask;
                        i_r        <= '0;
                        acc_r      <= 32'd0;
                        busy_r     <= 1'b1;
                        if (evl == 6'd0) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (skip_s) begin
                        i_r   <= i_r + 1'b1;
                        acc_r <= acc_r + stride_r;
                        if (last_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                        end
                    end else if (misaligned_s) begin
                        state_r    <= ST_ERR;
                        err_r      <= 1'b1;
                        err_elem_r <= i_r;
                    end else if (mreq_ready) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (mresp_valid) begin
                        i_r   <= i_r + 1'b1;
                        acc_r <= acc_r + stride_r;
                        if (last_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    i_r     <= '0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    i_r     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32v_mem_sequencer.sv
// Directed bench for rv32v_mem_sequencer: hand-computed vectors checked with
// immediate assertions, one linear stimulus sequence.
module tb_rv32v_mem_sequencer;
    import rv32v_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [31:0] base_addr, stride, vmask, vs2_rdata, vs3_rdata, mresp_rdata;
    logic [1:0]  mode, deew, ieew;
    logic [5:0]  evl;
    logic        is_store, mask_en, mreq_ready, mresp_valid;
    logic [4:0]  elem_idx, wb_elem, err_elem;
    logic        mreq_valid, mwen, wb_en, busy, done, err;
    logic [31:0] maddr, mwdata, wb_data;
    logic [3:0]  mbyte_en;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] t2_addr [3] = '{32'h0000_0200, 32'h0000_01FE, 32'h0000_01FC};
    logic [3:0]  t2_be   [3] = '{4'b0011, 4'b1100, 4'b0011};
    logic [31:0] t2_wd   [3] = '{32'hCAFE_0000, 32'h0001_0000, 32'hCAFE_0002};

    always #5 CLK = ~CLK;

    // VRF model: index and store data are simple functions of elem_idx.
    assign vs2_rdata = 32'h1234_5600 + 32'(elem_idx) * 32'd5;
    assign vs3_rdata = {16'hCAFE, 11'd0, elem_idx};

    rv32v_mem_sequencer dut (
        .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr), .stride(stride),
        .mode(mode), .deew(deew), .ieew(ieew), .evl(evl), .is_store(is_store),
        .mask_en(mask_en), .vmask(vmask), .elem_idx(elem_idx), .vs2_rdata(vs2_rdata),
        .vs3_rdata(vs3_rdata), .mreq_valid(mreq_valid), .maddr(maddr), .mwen(mwen),
        .mbyte_en(mbyte_en), .mwdata(mwdata), .mreq_ready(mreq_ready),
        .mresp_valid(mresp_valid), .mresp_rdata(mresp_rdata), .wb_en(wb_en),
        .wb_elem(wb_elem), .wb_data(wb_data), .busy(busy), .done(done), .err(err),
        .err_elem(err_elem)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic cmd(input logic [31:0] b, input logic [31:0] s, input logic [1:0] md,
                       input logic [1:0] de, input logic [1:0] ie, input logic [5:0] ev,
                       input logic st, input logic me, input logic [31:0] vm);
        base_addr = b; stride = s; mode = md; deew = de; ieew = ie;
        evl = ev; is_store = st; mask_en = me; vmask = vm; start = 1'b1;
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; base_addr = 32'd0; stride = 32'd0; vmask = 32'd0;
        mode = 2'd0; deew = 2'd0; ieew = 2'd0; evl = 6'd0; is_store = 1'b0;
        mask_en = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_rdata = 32'd0;
        step(); step();
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
        chk("rst_mreq", mreq_valid, 0); chk("rst_maddr", maddr, 0);
        chk("rst_idx", elem_idx, 0); chk("rst_wb", wb_en, 0);
        RST = 1'b0;
        step();

        // Unit-stride SEW32 load, immediate ready and response
        mreq_ready = 1'b1; mresp_valid = 1'b1;
        cmd(32'h100, 32'd0, VM_UNIT, SEW32, SEW8, 6'd4, 1'b0, 1'b0, 32'd0);
        step(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t1_valid", mreq_valid, 1);
            chk("t1_addr", maddr, 32'h100 + 32'(k) * 32'd4);
            chk("t1_be", mbyte_en, 4'hF);
            chk("t1_wen", mwen, 0);
            mresp_rdata = 32'hD000_0000 + 32'(k);
            step();
            chk("t1_wb_en", wb_en, 1);
            chk("t1_wb_elem", wb_elem, 32'(k));
            chk("t1_wb_data", wb_data, 32'hD000_0000 + 32'(k));
            chk("t1_wait_noreq", mreq_valid, 0);
            step();
        end
        chk("t1_done", done, 1); chk("t1_busy", busy, 1);
        step();
        chk("t1_done_clr", done, 0); chk("t1_idle", busy, 0);

        // Strided store, negative stride, SEW16
        cmd(32'h200, 32'hFFFF_FFFE, VM_STRIDED, SEW16, SEW8, 6'd3, 1'b1, 1'b0, 32'd0);
        step(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t2_valid", mreq_valid, 1);
            chk("t2_addr", maddr, t2_addr[k]);
            chk("t2_be", mbyte_en, t2_be[k]);
            chk("t2_wdata", mwdata, t2_wd[k]);
            chk("t2_wen", mwen, 1);
            step();
            chk("t2_no_wb", wb_en, 0);
            step();
        end
        chk("t2_done", done, 1);
        step();

        // Masked load: only elements 0 and 2 active
        cmd(32'h100, 32'd0, VM_UNIT, SEW32, SEW8, 6'd4, 1'b0, 1'b1, 32'b0101);
        mresp_rdata = 32'h0000_00AA;
        step(); start = 1'b0;
        chk("t3_req0", mreq_valid, 1); chk("t3_addr0", maddr, 32'h100);
        step();
        chk("t3_wb0", wb_en, 1); chk("t3_wb_elem0", wb_elem, 0);
        step();
        chk("t3_skip1", mreq_valid, 0); chk("t3_idx1", elem_idx, 1); chk("t3_nowb1", wb_en, 0);
        step();
        chk("t3_req2", mreq_valid, 1); chk("t3_addr2", maddr, 32'h108);
        step();
        chk("t3_wb2", wb_en, 1); chk("t3_wb_elem2", wb_elem, 2);
        step();
        chk("t3_skip3", mreq_valid, 0); chk("t3_idx3", elem_idx, 3); chk("t3_nodone3", done, 0);
        step();
        chk("t3_done", done, 1);
        step();

        // Misaligned SEW32 at 0x102
        cmd(32'h102, 32'd0, VM_UNIT, SEW32, SEW8, 6'd2, 1'b0, 1'b0, 32'd0);
        step(); start = 1'b0;
        chk("t4_noreq", mreq_valid, 0); chk("t4_err_early", err, 0);
        step();
        chk("t4_err", err, 1); chk("t4_err_elem", err_elem, 0);
        chk("t4_no_done", done, 0); chk("t4_busy", busy, 1);
        step();
        chk("t4_err_clr", err, 0); chk("t4_no_done2", done, 0); chk("t4_idle", busy, 0);

        // evl = 0
        cmd(32'h100, 32'd0, VM_UNIT, SEW32, SEW8, 6'd0, 1'b0, 1'b0, 32'd0);
        step(); start = 1'b0;
        chk("t5_done", done, 1); chk("t5_noreq", mreq_valid, 0);
        step();
        chk("t5_done_clr", done, 0); chk("t5_idle", busy, 0);

        // Request held under backpressure: SEW8 store at 0x401
        mreq_ready = 1'b0; mresp_valid = 1'b0;
        cmd(32'h401, 32'd0, VM_UNIT, SEW8, SEW8, 6'd1, 1'b1, 1'b0, 32'd0);
        step(); start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t6_valid", mreq_valid, 1);
            chk("t6_addr", maddr, 32'h401);
            chk("t6_be", mbyte_en, 4'b0010);
            chk("t6_wdata", mwdata, 32'hFE00_0000);
            step();
        end
        mreq_ready = 1'b1;
        step();
        chk("t6_wait", mreq_valid, 0); chk("t6_busy", busy, 1);
        mresp_valid = 1'b1;
        step();
        chk("t6_done", done, 1);
        step();

        // Reset while waiting for a response
        mresp_valid = 1'b0;
        cmd(32'h100, 32'd0, VM_UNIT, SEW32, SEW8, 6'd2, 1'b0, 1'b0, 32'd0);
        step(); start = 1'b0;
        chk("t7_req", mreq_valid, 1);
        step();
        chk("t7_in_wait", busy, 1);
        mresp_valid = 1'b1; mresp_rdata = 32'h0000_5555; RST = 1'b1;
        #1;
        chk("t7_rst_busy", busy, 0); chk("t7_rst_wb", wb_en, 0);
        chk("t7_rst_idx", elem_idx, 0); chk("t7_rst_maddr", maddr, 0);
        step();
        RST = 1'b0;
        step();
        chk("t7_post_wb", wb_en, 0); chk("t7_post_busy", busy, 0);
        cmd(32'h100, 32'd0, VM_UNIT, SEW32, SEW8, 6'd1, 1'b0, 1'b0, 32'd0);
        step(); start = 1'b0;
        chk("t7_run_addr", maddr, 32'h100); chk("t7_run_valid", mreq_valid, 1);
        mresp_rdata = 32'h0000_0077;
        step();
        chk("t7_run_wb", wb_en, 1); chk("t7_run_data", wb_data, 32'h77);
        step();
        chk("t7_run_done", done, 1);
        step();

        // Indexed SEW8 load with SEW8 indices (index = 5*i)
        cmd(32'h300, 32'd0, VM_INDEXED, SEW8, SEW8, 6'd2, 1'b0, 1'b0, 32'd0);
        mresp_rdata = 32'h4433_2211;
        step(); start = 1'b0;
        chk("t8_addr0", maddr, 32'h300); chk("t8_be0", mbyte_en, 4'b0001);
        step();
        chk("t8_wb0", wb_data, 32'h11);
        step();
        chk("t8_addr1", maddr, 32'h305); chk("t8_be1", mbyte_en, 4'b0010);
        step();
        chk("t8_wb1", wb_data, 32'h22); chk("t8_wb_elem1", wb_elem, 1);
        step();
        chk("t8_done", done, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
